// File: rtl/cache_arb_pkg.sv
// rtl/cache_arb_pkg.sv - shared types and defaults for the memory port arbiter
// Purpose: FSM state encoding, block layout and parameter defaults shared by the
//          arbiter, its round-robin picker and the lab memory model.
// Contents: state_e, block_t, DEF_ADDR_W, DEF_BLOCK_BYTES
package cache_arb_pkg;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_BLOCK_BYTES = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LO,
    WAIT_HI,
    RESP
  } state_e;

  // Byte-addressable block, byte 0 in the low bits, same layout as the memory model.
  typedef logic [DEF_BLOCK_BYTES-1:0][7:0] block_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
// Purpose: choose the first set request at or after (last+1) mod N, wrapping.
// Ports:
//   req     in  N           pending requests
//   last    in  $clog2(N)   most recently served index
//   gnt_id  out $clog2(N)   chosen index (meaningful only when any_gnt)
//   any_gnt out 1           at least one request pending
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] gnt_id,
  output logic          any_gnt
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             start_i;
  int             off;
  int             sum;

  // Rotate so the highest-priority requester lands at bit 0, priority-encode
  // the lowest set bit, then rotate the index back. Modulo N is explicit so
  // non-power-of-two N wraps correctly.
  always_comb begin
    start_i = (int'(last) >= N - 1) ? 0 : int'(last) + 1;
    dbl     = {req, req};
    rot     = dbl[start_i +: N];
    any_gnt = |req;
    off     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    sum = start_i + off;
    if (sum >= N) sum = sum - N;
    gnt_id = IW'(sum);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin sharing of the single memory port
// Purpose: grant one pending cache controller at a time, run the memory
//          req/ready handshake for it and return the completion to it only.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/write/addr/wdata  per-requester request, packed by requester index
//   resp_valid                  one-hot completion pulse
//   resp_rdata                  read block returned with the pulse
//   busy                        transaction in flight
//   mem_req_valid/write/addr/data_out  memory-side request
//   mem_ready, mem_data_in      memory-side status and read block
module mem_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int BLOCK_BYTES = DEF_BLOCK_BYTES,
  parameter int DATA_W      = BLOCK_BYTES * 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      busy,
  output logic                      mem_req_valid,
  output logic                      mem_write,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_data_out,
  input  logic                      mem_ready,
  input  logic [DATA_W-1:0]         mem_data_in
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_e          state, state_nxt;
  logic            grant;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   win_id;
  logic [IW-1:0]   pick_id;
  logic            pick_any;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req     (req_valid),
    .last    (last_grant),
    .gnt_id  (pick_id),
    .any_gnt (pick_any)
  );

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any && mem_ready) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = WAIT_LO;
      WAIT_LO: if (!mem_ready) state_nxt = WAIT_HI;
      WAIT_HI: if (mem_ready) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one is a clean flop
  // that tracks the current state exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= IW'(NUM_REQ - 1);
      win_id        <= '0;
      resp_valid    <= '0;
      resp_rdata    <= '0;
      busy          <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_write     <= 1'b0;
      mem_addr      <= '0;
      mem_data_out  <= '0;
    end else begin
      state         <= state_nxt;
      busy          <= (state_nxt != IDLE);
      mem_req_valid <= (state_nxt == ISSUE);
      resp_valid    <= (state_nxt == RESP) ? (ONE_HOT0 << win_id) : '0;

      if (grant) begin
        win_id       <= pick_id;
        mem_write    <= req_write[pick_id];
        mem_addr     <= req_addr[pick_id*ADDR_W +: ADDR_W];
        mem_data_out <= req_wdata[pick_id*DATA_W +: DATA_W];
      end else if (state == RESP) begin
        // Memory-side fields stay stable through RESP, then return to zero.
        last_grant   <= win_id;
        mem_write    <= 1'b0;
        mem_addr     <= '0;
        mem_data_out <= '0;
      end

      if (state == WAIT_HI && mem_ready && !mem_write) begin
        resp_rdata <= mem_data_in;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import cache_arb_pkg::*;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 128;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]   resp_valid;
  logic [DW-1:0]   resp_rdata;
  logic            busy;
  logic            mem_req_valid;
  logic            mem_write;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_data_out;
  logic            mem_ready;
  logic [DW-1:0]   mem_data_in;

  mem_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .BLOCK_BYTES(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .busy          (busy),
    .mem_req_valid (mem_req_valid),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_data_out  (mem_data_out),
    .mem_ready     (mem_ready),
    .mem_data_in   (mem_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           id;
    logic         wr;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t     sb[$];
  int       grant_log[$];
  int       checks = 0;
  int       failures = 0;
  int       tb_last = NR - 1;
  logic     in_flight = 1'b0;
  logic     hold_w;
  logic [AW-1:0] hold_a;
  logic [DW-1:0] hold_d;
  logic     mem_pend = 1'b0;
  int       mem_cnt = 0;
  int       mem_delay = 0;
  int       next_delay = 0;
  logic [AW-1:0] mem_lat_addr = '0;
  int       resp_count[NR];
  int       wait_cnt[NR];
  int       mreq_count = 0;
  int       completed = 0;

  function automatic logic [DW-1:0] rd_pat(input logic [AW-1:0] a);
    return {a ^ 32'h5A5A0000, ~a, a + 32'h00001111, a ^ 32'hDEADBEEF};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic raise(input int id, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[id]         = wr;
    req_addr[id*AW +: AW] = a;
    req_wdata[id*DW +: DW] = d;
    req_valid[id]         = 1'b1;
    wait_cnt[id]          = 0;
  endtask

  // One clock: observe at the falling edge, check against the model, then
  // advance the memory model and the requester drop-on-resp behaviour.
  task automatic step();
    int   id;
    int   worst;
    exp_t e;
    @(negedge clk);
    if (rst) begin
      mem_ready = 1'b1;
      mem_pend  = 1'b0;
      mem_cnt   = 0;
      in_flight = 1'b0;
      tb_last   = NR - 1;
      sb.delete();
    end else begin
      if (mem_req_valid) begin
        chk("mem_req_while_not_ready", mem_ready, 1);
        chk("one_in_flight", in_flight, 0);
        id = -1;
        for (int k = 1; k <= NR; k++) begin
          if (id < 0 && req_valid[(tb_last + k) % NR]) id = (tb_last + k) % NR;
        end
        chk("grant_has_request", id >= 0, 1);
        if (id >= 0) begin
          chk("grant_write", mem_write, req_write[id]);
          chk("grant_addr", mem_addr, req_addr[id*AW +: AW]);
          if (req_write[id]) chk("grant_wdata", mem_data_out, req_wdata[id*DW +: DW]);
          e.id = id; e.wr = req_write[id]; e.rdata = rd_pat(req_addr[id*AW +: AW]);
          sb.push_back(e);
          grant_log.push_back(id);
        end
        in_flight = 1'b1;
        hold_w = mem_write; hold_a = mem_addr; hold_d = mem_data_out;
        mreq_count++;
      end else if (in_flight) begin
        chk("stable_write", mem_write, hold_w);
        chk("stable_addr", mem_addr, hold_a);
        chk("stable_data", mem_data_out, hold_d);
      end
      chk("busy", busy, in_flight);

      if (resp_valid != '0) begin
        if (sb.size() == 0) begin
          chk("resp_unexpected", resp_valid, 0);
        end else begin
          e = sb.pop_front();
          chk("resp_onehot", resp_valid, 4'b0001 << e.id);
          if (!e.wr) chk("resp_rdata", resp_rdata, e.rdata);
          resp_count[e.id]++;
          worst = 0;
          for (int i = 0; i < NR; i++) begin
            if (i != e.id && req_valid[i]) wait_cnt[i]++;
            if (wait_cnt[i] > worst && i != e.id) worst = wait_cnt[i];
          end
          wait_cnt[e.id] = 0;
          chk("starvation_bound", worst <= NR - 1, 1);
          tb_last = e.id;
          req_valid[e.id] = 1'b0;
          completed++;
        end
        in_flight = 1'b0;
      end

      // Memory model: ready drops the cycle after it sees the strobe and stays
      // low for delay+1 cycles; read data is presented as ready rises.
      if (mem_pend) begin
        mem_ready = 1'b0;
        mem_cnt   = next_delay;
        mem_pend  = 1'b0;
      end else if (!mem_ready) begin
        if (mem_cnt == 0) begin
          mem_ready   = 1'b1;
          mem_data_in = rd_pat(mem_lat_addr);
        end else begin
          mem_cnt--;
        end
      end
      if (mem_req_valid) begin
        mem_pend     = 1'b1;
        mem_lat_addr = mem_addr;
        next_delay   = (mem_delay < 0) ? int'($urandom_range(0, 7)) : mem_delay;
      end
    end
  endtask

  task automatic run_until(input string tag, input int target, input int max_cycles);
    int n;
    n = 0;
    while (completed < target && n < max_cycles) begin
      step();
      n++;
    end
    chk(tag, completed, target);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_rdata"}, resp_rdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
    chk({tag, "_mem_write"}, mem_write, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_data_out"}, mem_data_out, 0);
  endtask

  int base_mreq;
  int base_done;
  int base_cnt;
  int issued;
  int cyc;

  initial begin
    rst = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b1; mem_data_in = '0;
    for (int i = 0; i < NR; i++) begin resp_count[i] = 0; wait_cnt[i] = 0; end

    // Reset: three cycles, all outputs quiet.
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;

    // Single read from requester 0, zero memory delay.
    mem_delay = 0;
    base_mreq = mreq_count; base_done = completed; grant_log.delete();
    raise(0, 1'b0, 32'h40, '0);
    run_until("single_read_done", base_done + 1, 50);
    chk("single_read_one_strobe", mreq_count - base_mreq, 1);
    chk("single_read_resp_count", resp_count[0], 1);
    chk("single_read_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);
    repeat (3) step();
    chk("single_read_no_extra_resp", completed, base_done + 1);

    // Round-robin from reset with all four requesting, twice.
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    mem_delay = 1;
    for (int pass = 0; pass < 2; pass++) begin
      grant_log.delete();
      base_done = completed;
      for (int i = 0; i < NR; i++) raise(i, 1'b0, 32'h1000 + 32'(i * 16), '0);
      run_until("rr_done", base_done + NR, 200);
      chk("rr_count", grant_log.size(), NR);
      for (int k = 0; k < NR; k++) begin
        chk("rr_order", k < grant_log.size() ? grant_log[k] : -1, k);
      end
    end

    // Write passthrough from requester 2.
    mem_delay = 3;
    base_done = completed; base_cnt = resp_count[2]; grant_log.delete();
    raise(2, 1'b1, 32'h80, {16{8'hA5}});
    run_until("write_done", base_done + 1, 60);
    chk("write_resp_count", resp_count[2], base_cnt + 1);
    chk("write_grant", grant_log.size() > 0 ? grant_log[0] : -1, 2);
    repeat (3) step();
    chk("write_no_extra_resp", completed, base_done + 1);

    // Random traffic, random memory delay 0..7.
    mem_delay = -1;
    base_done = completed; base_mreq = mreq_count;
    issued = 0; cyc = 0;
    while ((completed - base_done) < 1000 && cyc < 40000) begin
      step();
      cyc++;
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && !resp_valid[i] && issued < 1000 && $urandom_range(0, 1) == 1) begin
          raise(i, 1'($urandom_range(0, 1)), {$urandom_range(0, 65535), 4'h0} & 32'hFFFF_FFF0,
                {$urandom, $urandom, $urandom, $urandom});
          issued++;
        end
      end
    end
    chk("random_completed", completed - base_done, 1000);
    chk("random_strobes", mreq_count - base_mreq, 1000);
    chk("random_scoreboard_empty", sb.size(), 0);

    // Reset while waiting for memory to come back ready.
    mem_delay = 5;
    base_cnt = resp_count[1];
    raise(1, 1'b0, 32'h100, '0);
    cyc = 0;
    while (mem_ready && cyc < 50) begin step(); cyc++; end
    chk("abort_mem_went_busy", mem_ready, 0);
    repeat (2) step();
    chk("abort_in_wait_hi", busy && !mem_ready, 1);
    rst = 1'b1;
    step();
    check_all_zero("abort_reset");
    chk("abort_no_resp", resp_count[1], base_cnt);
    rst = 1'b0;
    base_done = completed;
    run_until("reissue_done", base_done + 1, 60);
    chk("reissue_resp_count", resp_count[1], base_cnt + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
